// File: rtl/dc_sync_pkg.sv
// ----------------------------------------------------------------------------
//  dc_sync_pkg
//  Shared constants and helpers for the dc_sync_filter_edge input conditioner.
//  Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package dc_sync_pkg;

  // Per-channel edge-mode encoding: bit 0 enables rise, bit 1 enables fall.
  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // Width of a counter that must hold 0..filter_len-1. It is never narrower
  // than one bit, so the bypass configuration still has a legal vector.
  function automatic int calc_cnt_w(input int filter_len);
    if (filter_len < 1) begin
      return 1;
    end
    return ($clog2(filter_len + 1) < 1) ? 1 : $clog2(filter_len + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dc_sync_filter_ch.sv
// ----------------------------------------------------------------------------
//  dc_sync_filter_ch
//  One channel: flop synchroniser, optional stability filter, and a
//  programmable edge detector that emits single-cycle pulses.
//  Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module dc_sync_filter_ch
  import dc_sync_pkg::*;
#(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0,
  parameter int   FILTER_LEN  = 0,
  parameter int   CNT_W       = calc_cnt_w(FILTER_LEN)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       d_in,
  input  logic [1:0] edge_mode,
  output logic       d_out,
  output logic       pulse_out
);

  // A single flop cannot give metastability a full cycle to resolve.
  if (STAGES < 2) begin : g_stages_check
    $error("dc_sync_filter_ch: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;
  logic              sy;
  logic              d_out_q;
  logic              d_prev_q;
  logic              rise;
  logic              fall;

  // Synchroniser chain: stage 0 samples the asynchronous input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_in};
    end
  end

  assign sy = sync_q[STAGES-1];

  if (FILTER_LEN == 0) begin : g_bypass
    // Without filtering the output register simply re-times sy.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        d_out_q <= RESET_VALUE;
      end else begin
        d_out_q <= sy;
      end
    end
  end else begin : g_filter
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             d_out_d;

    // Count consecutive mismatch cycles; commit sy once the run is long
    // enough, and restart from zero whenever sy agrees with d_out again.
    always_comb begin
      cnt_d   = '0;
      d_out_d = d_out_q;
      if (sy != d_out_q) begin
        if (cnt_q == CNT_LAST) begin
          d_out_d = sy;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt_q   <= '0;
        d_out_q <= RESET_VALUE;
      end else begin
        cnt_q   <= cnt_d;
        d_out_q <= d_out_d;
      end
    end
  end

  // Previous output value; reset equal to d_out so release makes no edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_prev_q <= RESET_VALUE;
    end else begin
      d_prev_q <= d_out_q;
    end
  end

  // Edges come from registers only; edge_mode gates them with no delay.
  assign rise      = d_out_q & ~d_prev_q;
  assign fall      = ~d_out_q & d_prev_q;
  assign pulse_out = (edge_mode[0] & rise) | (edge_mode[1] & fall);
  assign d_out     = d_out_q;

endmodule

`default_nettype wire

// File: rtl/dc_sync_filter_edge.sv
// ----------------------------------------------------------------------------
//  dc_sync_filter_edge
//  Multi-channel CDC input conditioner: WIDTH independent synchroniser /
//  glitch filter / edge detector channels plus an any-change flag.
//  Channels are independent; no cross-channel coherency is implied.
//  Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module dc_sync_filter_edge
  import dc_sync_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               FILTER_LEN  = 0,
  parameter int               CNT_W       = calc_cnt_w(FILTER_LEN)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     d_in,
  input  logic [2*WIDTH-1:0]   edge_mode,
  output logic [WIDTH-1:0]     d_out,
  output logic [WIDTH-1:0]     pulse_out,
  output logic                 chg_any
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    dc_sync_filter_ch #(
      .STAGES      (STAGES),
      .RESET_VALUE (RESET_VALUE[i]),
      .FILTER_LEN  (FILTER_LEN),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .d_in      (d_in[i]),
      .edge_mode (edge_mode[2*i +: 2]),
      .d_out     (d_out[i]),
      .pulse_out (pulse_out[i])
    );
  end

  assign chg_any = |pulse_out;

endmodule

`default_nettype wire

// File: tb/tb_dc_sync_filter_edge.sv
// ----------------------------------------------------------------------------
//  tb_dc_sync_filter_edge
//  Directed bench: a filtered instance (FILTER_LEN=4) and a bypass instance
//  (FILTER_LEN=0), both WIDTH=4, STAGES=3, RESET_VALUE=4'b0101.
//  Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dc_sync_filter_edge;
  import dc_sync_pkg::*;

  logic       clk;
  logic       rstn;

  logic [3:0] d_in;
  logic [7:0] edge_mode;
  logic [3:0] d_out;
  logic [3:0] pulse_out;
  logic       chg_any;

  logic [3:0] d_in0;
  logic [7:0] edge_mode0;
  logic [3:0] d_out0;
  logic [3:0] pulse_out0;
  logic       chg_any0;

  int n_checks;
  int n_fail;

  dc_sync_filter_edge #(
    .WIDTH       (4),
    .STAGES      (3),
    .RESET_VALUE (4'b0101),
    .FILTER_LEN  (4)
  ) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .d_in      (d_in),
    .edge_mode (edge_mode),
    .d_out     (d_out),
    .pulse_out (pulse_out),
    .chg_any   (chg_any)
  );

  dc_sync_filter_edge #(
    .WIDTH       (4),
    .STAGES      (3),
    .RESET_VALUE (4'b0101),
    .FILTER_LEN  (0)
  ) u_dut0 (
    .clk       (clk),
    .rstn      (rstn),
    .d_in      (d_in0),
    .edge_mode (edge_mode0),
    .d_out     (d_out0),
    .pulse_out (pulse_out0),
    .chg_any   (chg_any0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rstn       = 1'b0;
    d_in       = 4'b0101;
    d_in0      = 4'b0101;
    edge_mode  = {4{EDGE_BOTH}};
    edge_mode0 = {4{EDGE_BOTH}};
    tick(2);
    n_checks++;
    if (d_out !== 4'b0101 || pulse_out !== 4'b0000 || chg_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: d_out=%b pulse=%b chg=%b, expected 0101/0000/0", d_out, pulse_out, chg_any);
    end
    rstn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      n_checks++;
      if (d_out !== 4'b0101 || pulse_out !== 4'b0000 || chg_any !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release_f4 cyc%0d: d_out=%b pulse=%b chg=%b, expected 0101/0000/0", c, d_out, pulse_out, chg_any);
      end
      n_checks++;
      if (d_out0 !== 4'b0101 || pulse_out0 !== 4'b0000 || chg_any0 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release_f0 cyc%0d: d_out=%b pulse=%b chg=%b, expected 0101/0000/0", c, d_out0, pulse_out0, chg_any0);
      end
    end
  endtask

  task automatic test_no_filter();
    edge_mode0 = {EDGE_NONE, EDGE_NONE, EDGE_RISE, EDGE_NONE};
    d_in0[1]   = 1'b1;
    tick(3);
    n_checks++;
    if (d_out0 !== 4'b0101) begin
      n_fail++;
      $display("FAIL nofilt_early: d_out=%b, expected 0101", d_out0);
    end
    tick(1);
    n_checks++;
    if (d_out0 !== 4'b0111 || pulse_out0 !== 4'b0010 || chg_any0 !== 1'b1) begin
      n_fail++;
      $display("FAIL nofilt_rise: d_out=%b pulse=%b chg=%b, expected 0111/0010/1", d_out0, pulse_out0, chg_any0);
    end
    tick(1);
    n_checks++;
    if (d_out0 !== 4'b0111 || pulse_out0 !== 4'b0000 || chg_any0 !== 1'b0) begin
      n_fail++;
      $display("FAIL nofilt_one_cycle: d_out=%b pulse=%b chg=%b, expected 0111/0000/0", d_out0, pulse_out0, chg_any0);
    end
    // Rise-only mode: a falling edge moves d_out but makes no pulse.
    d_in0[1] = 1'b0;
    tick(4);
    n_checks++;
    if (d_out0 !== 4'b0101 || pulse_out0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL nofilt_fall_masked: d_out=%b pulse=%b, expected 0101/0000", d_out0, pulse_out0);
    end
  endtask

  task automatic test_glitch_filter();
    int bad;
    edge_mode = {4{EDGE_BOTH}};
    d_in[3]   = 1'b1;
    tick(3);
    d_in[3]   = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (d_out !== 4'b0101 || pulse_out !== 4'b0000) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL glitch_rejected: %0d bad cycles, last d_out=%b pulse=%b, expected 0101/0000", bad, d_out, pulse_out);
    end
    d_in[3] = 1'b1;
    tick(6);
    n_checks++;
    if (d_out !== 4'b0101 || pulse_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL filt_early: d_out=%b pulse=%b, expected 0101/0000", d_out, pulse_out);
    end
    tick(1);
    n_checks++;
    if (d_out !== 4'b1101 || pulse_out !== 4'b1000 || chg_any !== 1'b1) begin
      n_fail++;
      $display("FAIL filt_rise7: d_out=%b pulse=%b chg=%b, expected 1101/1000/1", d_out, pulse_out, chg_any);
    end
    tick(1);
    n_checks++;
    if (pulse_out !== 4'b0000 || chg_any !== 1'b0) begin
      n_fail++;
      $display("FAIL filt_pulse_width: pulse=%b chg=%b, expected 0000/0", pulse_out, chg_any);
    end
    d_in[3] = 1'b0;
    tick(10);
    n_checks++;
    if (d_out !== 4'b0101) begin
      n_fail++;
      $display("FAIL filt_settle: d_out=%b, expected 0101", d_out);
    end
  endtask

  task automatic test_both_edges();
    edge_mode = {EDGE_NONE, EDGE_BOTH, EDGE_NONE, EDGE_NONE};
    d_in[2]   = 1'b0;
    tick(6);
    n_checks++;
    if (d_out !== 4'b0101 || pulse_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL both_fall_early: d_out=%b pulse=%b, expected 0101/0000", d_out, pulse_out);
    end
    tick(1);
    n_checks++;
    if (d_out !== 4'b0001 || pulse_out !== 4'b0100 || chg_any !== 1'b1) begin
      n_fail++;
      $display("FAIL both_fall: d_out=%b pulse=%b chg=%b, expected 0001/0100/1", d_out, pulse_out, chg_any);
    end
    tick(1);
    n_checks++;
    if (pulse_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL both_fall_width: pulse=%b, expected 0000", pulse_out);
    end
    tick(4);
    d_in[2] = 1'b1;
    tick(7);
    n_checks++;
    if (d_out !== 4'b0101 || pulse_out !== 4'b0100 || chg_any !== 1'b1) begin
      n_fail++;
      $display("FAIL both_rise: d_out=%b pulse=%b chg=%b, expected 0101/0100/1", d_out, pulse_out, chg_any);
    end
    tick(1);
    n_checks++;
    if (pulse_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL both_rise_width: pulse=%b, expected 0000", pulse_out);
    end
    // Mode none: level still follows, no pulses.
    edge_mode = {4{EDGE_NONE}};
    d_in[2]   = 1'b0;
    tick(7);
    n_checks++;
    if (d_out !== 4'b0001 || pulse_out !== 4'b0000 || chg_any !== 1'b0) begin
      n_fail++;
      $display("FAIL none_fall: d_out=%b pulse=%b chg=%b, expected 0001/0000/0", d_out, pulse_out, chg_any);
    end
    tick(3);
    d_in[2] = 1'b1;
    tick(7);
    n_checks++;
    if (d_out !== 4'b0101 || pulse_out !== 4'b0000 || chg_any !== 1'b0) begin
      n_fail++;
      $display("FAIL none_rise: d_out=%b pulse=%b chg=%b, expected 0101/0000/0", d_out, pulse_out, chg_any);
    end
    tick(3);
  endtask

  task automatic test_simultaneous();
    edge_mode = {4{EDGE_BOTH}};
    d_in      = 4'b1010;
    tick(6);
    n_checks++;
    if (d_out !== 4'b0101 || pulse_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL simul_early: d_out=%b pulse=%b, expected 0101/0000", d_out, pulse_out);
    end
    tick(1);
    n_checks++;
    if (d_out !== 4'b1010 || pulse_out !== 4'b1111 || chg_any !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_flip: d_out=%b pulse=%b chg=%b, expected 1010/1111/1", d_out, pulse_out, chg_any);
    end
    tick(1);
    n_checks++;
    if (d_out !== 4'b1010 || pulse_out !== 4'b0000 || chg_any !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_width: d_out=%b pulse=%b chg=%b, expected 1010/0000/0", d_out, pulse_out, chg_any);
    end
    d_in = 4'b0101;
    tick(10);
    n_checks++;
    if (d_out !== 4'b0101) begin
      n_fail++;
      $display("FAIL simul_restore: d_out=%b, expected 0101", d_out);
    end
  endtask

  task automatic test_mode_change();
    edge_mode = {4{EDGE_NONE}};
    d_in[1]   = 1'b1;
    tick(7);
    n_checks++;
    if (d_out !== 4'b0111 || pulse_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL mode_before: d_out=%b pulse=%b, expected 0111/0000", d_out, pulse_out);
    end
    // Same edge cycle, mode switched to rise: the pulse appears at once.
    edge_mode = {EDGE_NONE, EDGE_NONE, EDGE_RISE, EDGE_NONE};
    #1;
    n_checks++;
    if (pulse_out !== 4'b0010 || chg_any !== 1'b1) begin
      n_fail++;
      $display("FAIL mode_immediate: pulse=%b chg=%b, expected 0010/1", pulse_out, chg_any);
    end
    tick(1);
    n_checks++;
    if (pulse_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL mode_width: pulse=%b, expected 0000", pulse_out);
    end
  endtask

  task automatic test_reset_midcount();
    // d_out is 0111 here; drive channel 0 low and abort its count at 2.
    edge_mode = {4{EDGE_BOTH}};
    d_in[0]   = 1'b0;
    tick(5);
    n_checks++;
    if (d_out !== 4'b0111) begin
      n_fail++;
      $display("FAIL midcount_pre: d_out=%b, expected 0111", d_out);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (d_out !== 4'b0101 || pulse_out !== 4'b0000 || chg_any !== 1'b0) begin
      n_fail++;
      $display("FAIL midcount_async_reset: d_out=%b pulse=%b chg=%b, expected 0101/0000/0", d_out, pulse_out, chg_any);
    end
    tick(2);
    rstn = 1'b1;
    tick(6);
    n_checks++;
    if (d_out !== 4'b0101 || pulse_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL midcount_restart_early: d_out=%b pulse=%b, expected 0101/0000", d_out, pulse_out);
    end
    tick(1);
    n_checks++;
    if (d_out !== 4'b0110 || pulse_out !== 4'b0011 || chg_any !== 1'b1) begin
      n_fail++;
      $display("FAIL midcount_restart_done: d_out=%b pulse=%b chg=%b, expected 0110/0011/1", d_out, pulse_out, chg_any);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rstn       = 1'b0;
    d_in       = 4'b0101;
    d_in0      = 4'b0101;
    edge_mode  = '0;
    edge_mode0 = '0;
    test_reset();
    test_no_filter();
    test_glitch_filter();
    test_both_edges();
    test_simultaneous();
    test_mode_change();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
